// File: rtl/grid_mem_arbiter.sv
// grid_mem_arbiter
//   Round-robin arbiter sharing one single-port memoryRAM between NREQ requesters.
//   One read or write is accepted per edge and issued on the memory port in the
//   following cycle. Read data returns one cycle later, tagged by a per-requester rvalid.
// Ports
//   clk, reset         clock (rising edge), asynchronous active-high reset
//   req, we            per-requester request and write-enable (we qualified by req)
//   addr, wdata        packed per-requester address / write data (requester i at [i*W +: W])
//   gnt, rvalid        one-hot pulses: request accepted / rdata valid for requester i
//   rdata              shared read data (mem_dout passed through)
//   mem_read/write     memory port strobes, never both high
//   mem_addr, mem_din  memory port address and write data (held while idle)
//   mem_dout           memory read data, one cycle after mem_read
module grid_mem_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned AW   = 32,
   parameter int unsigned DW   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   we,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   rvalid,
   output logic [DW-1:0]     rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_din,
   input  logic [DW-1:0]     mem_dout
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] OneHot0 = NREQ'(1);

   typedef enum logic {StIdle, StIssue} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]   gnt_idx_q, gnt_idx_d;
   logic            op_we_q, op_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_din_q, mem_din_d;
   logic            tag_valid_q, tag_valid_d;
   logic [PW-1:0]   tag_idx_q, tag_idx_d;

   logic [NREQ-1:0] eligible;
   logic [PW-1:0]   win_idx;
   logic            any_elig;
   int unsigned     cand;

   // Port outputs are decoded from the issue state so reset clears them at once.
   assign gnt       = (state_q == StIssue) ? (OneHot0 << gnt_idx_q) : '0;
   assign mem_read  = (state_q == StIssue) & ~op_we_q;
   assign mem_write = (state_q == StIssue) &  op_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;
   assign rvalid    = tag_valid_q ? (OneHot0 << tag_idx_q) : '0;
   assign rdata     = mem_dout;

   // The requester holding the current grant sits out the next edge, so a lone
   // requester gets every other cycle and others can slot in between.
   assign eligible = req & ~gnt;

   // First eligible requester at or above rr_ptr, wrapping.
   always_comb begin
      win_idx  = '0;
      any_elig = 1'b0;
      cand     = 0;
      for (int unsigned j = 0; j < NREQ; j++) begin
         cand = 32'(rr_ptr_q) + j;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (!any_elig && eligible[PW'(cand)]) begin
            any_elig = 1'b1;
            win_idx  = PW'(cand);
         end
      end
   end

   always_comb begin
      state_d     = StIdle;
      rr_ptr_d    = rr_ptr_q;
      gnt_idx_d   = gnt_idx_q;
      op_we_d     = op_we_q;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;
      // A read on the port this cycle returns data next cycle.
      tag_valid_d = mem_read;
      tag_idx_d   = gnt_idx_q;
      if (any_elig) begin
         state_d    = StIssue;
         gnt_idx_d  = win_idx;
         op_we_d    = we[win_idx];
         mem_addr_d = addr[win_idx*AW +: AW];
         mem_din_d  = wdata[win_idx*DW +: DW];
         rr_ptr_d   = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         gnt_idx_q   <= '0;
         op_we_q     <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         tag_valid_q <= 1'b0;
         tag_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_idx_q   <= gnt_idx_d;
         op_we_q     <= op_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         tag_valid_q <= tag_valid_d;
         tag_idx_q   <= tag_idx_d;
      end
   end

endmodule
